// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter: 8 requesters, registered one-hot grant + index.
// Optional hold timeout enabled by defining ARB_TIMEOUT_EN.
module rr_arbiter_8 #(
    parameter int N     = 8,
    parameter int IDX_W = 3
`ifdef ARB_TIMEOUT_EN
    ,
    parameter int MAX_HOLD = 16
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             timeout
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [N-1:0]     gnt_q, gnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             valid_q, valid_d;

`ifdef ARB_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              to_q, to_d;
`endif

    // Circular search: returns {found, index} of first set bit at/after ptr.
    function automatic logic [IDX_W:0] search(
        input logic [IDX_W-1:0] ptr,
        input logic [N-1:0]     mask
    );
        logic             found;
        logic [IDX_W-1:0] idx;
        logic [IDX_W-1:0] cand;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            cand = ptr + IDX_W'(i);
            if (!found && mask[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        return {found, idx};
    endfunction

    logic [N-1:0]     own_mask;
    logic [N-1:0]     others;
    logic [IDX_W-1:0] nxt_ptr;
    logic [IDX_W:0]   srch_idle;
    logic [IDX_W:0]   srch_rel;

    // Candidate winners for the idle search and for release/rotation.
    always_comb begin
        own_mask  = N'(1) << idx_q;
        others    = req & ~own_mask;
        nxt_ptr   = idx_q + IDX_W'(1);
        srch_idle = search(ptr_q, req);
        srch_rel  = search(nxt_ptr, others);
    end

    // Next-state and output decode; enable low overrides everything.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        valid_d = valid_q;
`ifdef ARB_TIMEOUT_EN
        hold_d  = hold_q;
        to_d    = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (enable && |req) begin
                    state_d = GRANT;
                    valid_d = 1'b1;
                    idx_d   = srch_idle[IDX_W-1:0];
                    gnt_d   = N'(1) << srch_idle[IDX_W-1:0];
`ifdef ARB_TIMEOUT_EN
                    hold_d  = '0;
`endif
                end
            end
            GRANT: begin
                if (!enable) begin
                    state_d = IDLE;
                    ptr_d   = nxt_ptr;
                    gnt_d   = '0;
                    idx_d   = '0;
                    valid_d = 1'b0;
                end else if (!req[idx_q]) begin
                    ptr_d = nxt_ptr;
                    if (srch_rel[IDX_W]) begin
                        idx_d = srch_rel[IDX_W-1:0];
                        gnt_d = N'(1) << srch_rel[IDX_W-1:0];
`ifdef ARB_TIMEOUT_EN
                        hold_d = '0;
`endif
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        idx_d   = '0;
                        valid_d = 1'b0;
                    end
`ifdef ARB_TIMEOUT_EN
                end else if (hold_q == HOLD_W'(MAX_HOLD - 1)) begin
                    // Force rotation only if someone else waits;
                    // otherwise keep the grant with hold_cnt saturated.
                    if (|others) begin
                        ptr_d  = nxt_ptr;
                        idx_d  = srch_rel[IDX_W-1:0];
                        gnt_d  = N'(1) << srch_rel[IDX_W-1:0];
                        hold_d = '0;
                        to_d   = 1'b1;
                    end
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
`endif
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                idx_d   = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            hold_q  <= '0;
            to_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
`ifdef ARB_TIMEOUT_EN
            hold_q  <= hold_d;
            to_q    <= to_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = idx_q;
    assign gnt_valid = valid_q;
`ifdef ARB_TIMEOUT_EN
    assign timeout   = to_q;
`else
    assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Self-checking bench for rr_arbiter_8 (vector table, sequences, random).
// Timeout scenarios compile in when ARB_TIMEOUT_EN is defined.
module tb_rr_arbiter_8;

    localparam int MAX_HOLD = 16;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int tests;
    int fails;

    // Reference model state: owner -1 means idle.
    int   m_owner;
    int   m_ptr;
    int   m_hold;
    logic m_to;

    rr_arbiter_8 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int first_req(input int p, input logic [7:0] r);
        int j;
        for (int k = 0; k < 8; k++) begin
            j = (p + k) % 8;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_hold  = 0;
        m_to    = 1'b0;
    endtask

    task automatic model_edge(input logic en, input logic [7:0] r);
        logic [7:0] rest;
        m_to = 1'b0;
        if (m_owner < 0) begin
            if (en && r != 8'h00) begin
                m_owner = first_req(m_ptr, r);
                m_hold  = 0;
            end
        end else if (!en) begin
            m_ptr   = (m_owner + 1) % 8;
            m_owner = -1;
        end else if (!r[m_owner]) begin
            m_ptr   = (m_owner + 1) % 8;
            m_owner = first_req(m_ptr, r);
            m_hold  = 0;
        end else begin
`ifdef ARB_TIMEOUT_EN
            rest = r & ~(8'h01 << m_owner);
            if (m_hold == MAX_HOLD - 1) begin
                if (rest != 8'h00) begin
                    m_ptr   = (m_owner + 1) % 8;
                    m_owner = first_req(m_ptr, rest);
                    m_hold  = 0;
                    m_to    = 1'b1;
                end
            end else begin
                m_hold = m_hold + 1;
            end
`else
            rest = r;
`endif
        end
    endtask

    task automatic step();
        model_edge(enable, req);
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic ev,
                         input int eidx, input logic eto);
        logic [7:0] eg;
        eg = ev ? (8'h01 << eidx) : 8'h00;
        tests++;
        if (gnt !== eg || gnt_valid !== ev ||
            (ev && gnt_idx !== 3'(eidx)) || timeout !== eto) begin
            fails++;
            $display("FAIL %s: gnt=%h valid=%b idx=%0d to=%b, expected gnt=%h valid=%b idx=%0d to=%b",
                     name, gnt, gnt_valid, gnt_idx, timeout, eg, ev, eidx, eto);
        end
    endtask

    task automatic check_model(input string name);
        check(name, m_owner >= 0, (m_owner < 0) ? 0 : m_owner, m_to);
    endtask

    typedef struct {
        logic       en;
        logic [7:0] rq;
        logic       v;
        int         idx;
    } vec_t;

    vec_t vecs[$];

    initial begin
        tests  = 0;
        fails  = 0;
        rst_n  = 1'b0;
        enable = 1'b0;
        req    = 8'h00;
        model_reset();

        // Rotation through all owners, wrap, enable drop.
        vecs.push_back('{1'b1, 8'hFF, 1'b1, 0});
        vecs.push_back('{1'b1, 8'hFE, 1'b1, 1});
        vecs.push_back('{1'b1, 8'hFC, 1'b1, 2});
        vecs.push_back('{1'b1, 8'hF8, 1'b1, 3});
        vecs.push_back('{1'b1, 8'hF0, 1'b1, 4});
        vecs.push_back('{1'b1, 8'hE0, 1'b1, 5});
        vecs.push_back('{1'b1, 8'hC0, 1'b1, 6});
        vecs.push_back('{1'b1, 8'h80, 1'b1, 7});
        vecs.push_back('{1'b1, 8'h00, 1'b0, 0});
        vecs.push_back('{1'b1, 8'h20, 1'b1, 5});
        vecs.push_back('{1'b1, 8'h00, 1'b0, 0});
        vecs.push_back('{1'b1, 8'h41, 1'b1, 6});
        vecs.push_back('{1'b1, 8'h01, 1'b1, 0});
        vecs.push_back('{1'b1, 8'h00, 1'b0, 0});
        vecs.push_back('{1'b1, 8'h08, 1'b1, 3});
        vecs.push_back('{1'b0, 8'h08, 1'b0, 0});
        vecs.push_back('{1'b1, 8'h09, 1'b1, 0});
        vecs.push_back('{1'b1, 8'h00, 1'b0, 0});

        // Reset values.
        #12;
        check("reset", 1'b0, 0, 1'b0);
        tests++;
        if (gnt_idx !== 3'd0) begin
            fails++;
            $display("FAIL reset_idx: idx=%0d expected 0", gnt_idx);
        end

        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        enable = 1'b1;
        req    = 8'h00;
        for (int i = 0; i < 10; i++) begin
            step();
            check("idle_noreq", 1'b0, 0, 1'b0);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            enable = vecs[i].en;
            req    = vecs[i].rq;
            step();
            check($sformatf("vec%0d", i), vecs[i].v, vecs[i].idx, 1'b0);
        end

        // Async reset mid-grant; search must restart from ptr=0.
        enable = 1'b1;
        req    = 8'h20;
        step();
        check("pre_rst_5", 1'b1, 5, 1'b0);
        req = 8'h00;
        step();
        check("pre_rst_idle", 1'b0, 0, 1'b0);
        req = 8'h40;
        step();
        check("pre_rst_6", 1'b1, 6, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst", 1'b0, 0, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        check("rst_held", 1'b0, 0, 1'b0);
        rst_n = 1'b1;
        req   = 8'h41;
        step();
        check("post_rst_ptr0", 1'b1, 0, 1'b0);
        req = 8'h00;
        step();
        check("post_rst_idle", 1'b0, 0, 1'b0);

`ifdef ARB_TIMEOUT_EN
        // Forced rotation after MAX_HOLD cycles, none when alone.
        rst_n = 1'b0;
        #1;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req   = 8'h03;
        step();
        check("to_hold_first", 1'b1, 0, 1'b0);
        for (int i = 1; i < MAX_HOLD; i++) begin
            step();
            check("to_hold", 1'b1, 0, 1'b0);
        end
        step();
        check("to_pulse", 1'b1, 1, 1'b1);
        step();
        check("to_after", 1'b1, 1, 1'b0);
        req = 8'h01;
        step();
        check("to_single", 1'b1, 0, 1'b0);
        for (int i = 0; i < 3 * MAX_HOLD; i++) begin
            step();
            check("to_none", 1'b1, 0, 1'b0);
        end
        req = 8'h00;
        step();
        check("to_idle", 1'b0, 0, 1'b0);
`endif

        // Random traffic against the model.
        for (int blk = 0; blk < 15; blk++) begin
            int churn;
            churn = (blk % 3 == 0) ? 40 : 4;
            for (int c = 0; c < 200; c++) begin
                enable = ($urandom_range(0, 11) != 0);
                if ($urandom_range(0, churn - 1) == 0) begin
                    req = 8'($urandom);
                    if ($urandom_range(0, 3) == 0) req = req & 8'($urandom);
                end else if (m_owner >= 0 &&
                             $urandom_range(0, churn - 1) == 0) begin
                    req[m_owner] = 1'b0;
                end
                step();
                check_model("rand");
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
